peripheral_msi_arbiter_bb: RTL and testbench
============================================

PERIPHERAL_MSI_ARBITER_BB -- requirements
Module: peripheral_msi_arbiter_bb

Interface
REQ-001 SHALL have parameter MASTERS, default 5: number of master ports competing for one slave port.
REQ-002 SHALL have parameter MASTER_BITS, default $clog2(MASTERS): width of the encoded grant.
REQ-003 SHALL have port HCLK, input, 1: clock, rising edge.
REQ-004 SHALL have port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port mst_req, input, MASTERS: per-master slvHSEL bit aimed at this slave.
REQ-006 SHALL have port mst_priority, input, MASTERS x 3: per-master priority; 7 is highest.
REQ-007 SHALL have port mst_can_switch, input, MASTERS: per-master "bus may change owner next cycle".
REQ-008 SHALL have port slv_HREADY, input, 1: HREADY of the addressed slave.
REQ-009 SHALL have port master_granted, output, MASTERS: one-hot grant, registered.
REQ-010 SHALL have port grant_sel, output, MASTER_BITS: encoded owner index, registered.
REQ-011 SHALL have port grant_valid, output, 1: high while any grant is active.

Function
REQ-012 SHALL implement states IDLE (no owner) and OWNED (exactly one owner).
REQ-013 IDLE with mst_req==0 SHALL stay in IDLE with master_granted==0.
REQ-014 IDLE with any mst_req SHALL arbitrate combinationally, register the winner, and go to OWNED; the grant becomes visible on the next cycle (latency 1).
REQ-015 Winner SHALL be the requester with the numerically highest mst_priority.
REQ-016 Ties SHALL be broken round-robin: the first tied requester at or after index (rr_ptr+1) mod MASTERS.
REQ-017 rr_ptr SHALL update to the winner index on every registered grant change.
REQ-018 In OWNED, the grant SHALL hold while mst_can_switch[owner]==0, whatever the other requests or the owner's own mst_req are (locked or burst transfer).
REQ-019 In OWNED, re-arbitration SHALL occur only when mst_can_switch[owner]==1 and slv_HREADY==1.
REQ-020 On re-arbitration, the owner SHALL compete normally; with equal priority it SHALL rank last because of rr_ptr.
REQ-021 On re-arbitration with mst_req==0, the block SHALL go to IDLE with master_granted==0 on the next cycle.
REQ-022 On re-arbitration where the owner is the sole requester, the grant SHALL remain unchanged with no idle cycle.
REQ-023 A request that rises and falls while the grant is held SHALL NOT be remembered.
REQ-024 master_granted SHALL always be zero or one-hot.
REQ-025 grant_sel SHALL equal the index of the set bit, or hold its last value when idle.
REQ-026 grant_valid SHALL equal |master_granted.
REQ-027 Priority values SHALL be used in the cycle they are sampled; no aging.

Reset
REQ-028 HRESETn low SHALL immediately force state=IDLE, master_granted=0, grant_sel=0, grant_valid=0, rr_ptr=MASTERS-1 (master 0 wins the first tie).
REQ-029 Reset during OWNED SHALL drop the grant immediately; arbitration SHALL restart from the reset values on the first edge after release.

Structure
REQ-030 The state enum SHALL live in peripheral_bb_pkg, alongside the existing HTRANS/HBURST constants.
REQ-031 The combinational priority and round-robin selection SHALL be one sub-module, peripheral_msi_rr_select, which takes req, priority and rr_ptr and returns a one-hot winner.
REQ-032 All state SHALL be in the top module.
REQ-033 Target size SHALL be 120-400 lines total.

Verification
REQ-034 Reset release, mst_req=5'b00110 with all priorities 0 -> master_granted=5'b00010 one cycle later, grant_sel=1.
REQ-035 Owner 1 with mst_can_switch[1]=0 for 4 cycles and mst_req[2]=1 -> grant held 4 cycles; switch to 5'b00100 one cycle after can_switch and slv_HREADY are both 1.
REQ-036 Priorities {m0=2, m3=6}, both requesting from IDLE -> grant 5'b01000; m3 releases with m0 still requesting -> grant 5'b00001.
REQ-037 All 5 masters request at equal priority, each releasing on grant -> grant order 0,1,2,3,4,0.
REQ-038 Owner alone requesting with can_switch=1 -> grant unchanged, no IDLE cycle; then mst_req=0 -> master_granted=0 next cycle.
REQ-039 HRESETn asserted mid-OWNED -> outputs 0 in the same cycle; after release, equal requests from m2 and m4 -> grant m2.

Source files
------------

// File: rtl/peripheral_bb_pkg.sv
// Shared AHB-side definitions for the peripheral bus block: transfer/burst
// encodings and the arbiter state type.
package peripheral_bb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Width of a master's priority field; 7 is the most urgent.
    localparam int PRIO_W = 3;

    // Arbiter ownership state: nobody owns the slave, or exactly one master does.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/peripheral_msi_rr_select.sv
// Combinational winner selection: highest priority among requesters, ties
// broken by scanning from the master after rr_ptr. Returns a one-hot vector
// (all zero when nobody requests).
module peripheral_msi_rr_select
    import peripheral_bb_pkg::*;
#(
    parameter int MASTERS     = 5,
    parameter int MASTER_BITS = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0]             req,
    input  logic [MASTERS-1:0][PRIO_W-1:0] prio,
    input  logic [MASTER_BITS-1:0]         rr_ptr,
    output logic [MASTERS-1:0]             winner
);

    // One extra bit so rr_ptr + offset (< 2*MASTERS) never overflows before wrap.
    localparam logic [MASTER_BITS:0] M_L = (MASTER_BITS + 1)'(MASTERS);

    logic [PRIO_W-1:0]      max_prio;
    logic [MASTER_BITS:0]   sum;
    logic [MASTER_BITS-1:0] idx;
    logic                   found;

    // Highest priority value present among the active requesters.
    always_comb begin : find_max
        max_prio = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (req[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end
    end

    // First requester at max priority, scanning rr_ptr+1, rr_ptr+2, ... so the
    // previous winner (rr_ptr itself) is considered last.
    always_comb begin : pick_winner
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            sum = {1'b0, rr_ptr} + (MASTER_BITS + 1)'(k);
            if (sum >= M_L) begin
                sum = sum - M_L;
            end
            idx = sum[MASTER_BITS-1:0];
            if (!found && req[idx] && (prio[idx] == max_prio)) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_msi_arbiter_bb.sv
// Multi-master to single-slave AHB arbiter. Holds the current owner until it
// signals it may switch and the slave is ready, then re-arbitrates by
// priority with round-robin tie-breaking.
module peripheral_msi_arbiter_bb
    import peripheral_bb_pkg::*;
#(
    parameter int MASTERS     = 5,
    parameter int MASTER_BITS = $clog2(MASTERS)
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [MASTERS-1:0]             mst_req,
    input  logic [MASTERS-1:0][PRIO_W-1:0] mst_priority,
    input  logic [MASTERS-1:0]             mst_can_switch,
    input  logic                           slv_HREADY,
    output logic [MASTERS-1:0]             master_granted,
    output logic [MASTER_BITS-1:0]         grant_sel,
    output logic                           grant_valid
);

    // Reset value of rr_ptr: the last master, so master 0 wins the first tie.
    localparam logic [MASTER_BITS-1:0] RR_RESET = MASTER_BITS'(MASTERS - 1);

    arb_state_e             state_q, state_d;
    logic [MASTERS-1:0]     granted_q, granted_d;
    logic [MASTER_BITS-1:0] sel_q, sel_d;
    logic [MASTER_BITS-1:0] rr_q, rr_d;

    logic [MASTERS-1:0]     winner;
    logic [MASTER_BITS-1:0] win_idx;

    peripheral_msi_rr_select #(
        .MASTERS     (MASTERS),
        .MASTER_BITS (MASTER_BITS)
    ) u_select (
        .req    (mst_req),
        .prio   (mst_priority),
        .rr_ptr (rr_q),
        .winner (winner)
    );

    // Encode the one-hot winner into an index.
    always_comb begin : encode_winner
        win_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (winner[i]) begin
                win_idx = MASTER_BITS'(i);
            end
        end
    end

    // Next-state: arbitrate from IDLE, or from OWNED once the owner allows a
    // switch and the slave is ready; otherwise hold everything.
    always_comb begin : next_state
        state_d   = state_q;
        granted_d = granted_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (|mst_req) begin
                    state_d   = ARB_OWNED;
                    granted_d = winner;
                    sel_d     = win_idx;
                    rr_d      = win_idx;
                end
            end
            ARB_OWNED: begin
                if (mst_can_switch[sel_q] && slv_HREADY) begin
                    if (|mst_req) begin
                        granted_d = winner;
                        sel_d     = win_idx;
                        rr_d      = win_idx;
                    end else begin
                        // Nobody wants the bus: release it, keep last grant_sel.
                        state_d   = ARB_IDLE;
                        granted_d = '0;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                granted_d = '0;
            end
        endcase
    end

    // State and grant registers, cleared asynchronously by HRESETn.
    always_ff @(posedge HCLK or negedge HRESETn) begin : state_regs
        if (!HRESETn) begin
            state_q   <= ARB_IDLE;
            granted_q <= '0;
            sel_q     <= '0;
            rr_q      <= RR_RESET;
        end else begin
            state_q   <= state_d;
            granted_q <= granted_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
        end
    end

    assign master_granted = granted_q;
    assign grant_sel      = sel_q;
    assign grant_valid    = |granted_q;

endmodule

// File: tb/tb_peripheral_msi_arbiter_bb.sv
// Directed self-checking bench for peripheral_msi_arbiter_bb (5 masters).
module tb_peripheral_msi_arbiter_bb;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [4:0]       mst_req;
    logic [4:0][2:0]  mst_priority;
    logic [4:0]       mst_can_switch;
    logic             slv_HREADY;
    logic [4:0]       master_granted;
    logic [2:0]       grant_sel;
    logic             grant_valid;

    int checks   = 0;
    int failures = 0;

    peripheral_msi_arbiter_bb #(.MASTERS(5)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .mst_req        (mst_req),
        .mst_priority   (mst_priority),
        .mst_can_switch (mst_can_switch),
        .slv_HREADY     (slv_HREADY),
        .master_granted (master_granted),
        .grant_sel      (grant_sel),
        .grant_valid    (grant_valid)
    );

    always #5 HCLK = ~HCLK;

    // Advance one clock and settle 1 ns after the rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn        = 1'b0;
        mst_req        = '0;
        mst_priority   = '0;
        mst_can_switch = '0;
        slv_HREADY     = 1'b1;
        tick();
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00000, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b/%0d/%b exp=00000/0/0", master_granted, grant_sel, grant_valid);
        end
        $display("txn reset: granted=%b sel=%0d valid=%b", master_granted, grant_sel, grant_valid);
    endtask

    task automatic test_basic_grant();
        HRESETn = 1'b1;
        mst_req = 5'b00110;
        #1;
        checks++;
        if (master_granted !== 5'b00000) begin
            failures++;
            $display("FAIL grant_not_before_edge got=%b exp=00000", master_granted);
        end
        tick();
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00010, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL basic_grant got=%b/%0d/%b exp=00010/1/1", master_granted, grant_sel, grant_valid);
        end
        $display("txn basic: granted=%b sel=%0d", master_granted, grant_sel);
    endtask

    task automatic test_hold_and_switch();
        mst_req        = 5'b00110;
        mst_can_switch = 5'b00000;
        slv_HREADY     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({master_granted, grant_sel} !== {5'b00010, 3'd1}) begin
                failures++;
                $display("FAIL hold_locked[%0d] got=%b/%0d exp=00010/1", c, master_granted, grant_sel);
            end
            $display("txn hold %0d: granted=%b", c, master_granted);
        end
        mst_can_switch = 5'b00010;
        slv_HREADY     = 1'b0;
        tick();
        checks++;
        if (master_granted !== 5'b00010) begin
            failures++;
            $display("FAIL hold_hready_low got=%b exp=00010", master_granted);
        end
        slv_HREADY = 1'b1;
        tick();
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00100, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL switch_to_m2 got=%b/%0d/%b exp=00100/2/1", master_granted, grant_sel, grant_valid);
        end
        $display("txn switch: granted=%b sel=%0d", master_granted, grant_sel);
        mst_req        = 5'b00000;
        mst_can_switch = 5'b11111;
        tick();
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00000, 3'd2, 1'b0}) begin
            failures++;
            $display("FAIL release_to_idle got=%b/%0d/%b exp=00000/2/0", master_granted, grant_sel, grant_valid);
        end
        $display("txn idle: granted=%b sel=%0d", master_granted, grant_sel);
    endtask

    task automatic test_priority();
        mst_priority    = '0;
        mst_priority[0] = 3'd2;
        mst_priority[3] = 3'd6;
        mst_req         = 5'b01001;
        mst_can_switch  = 5'b00000;
        tick();
        checks++;
        if ({master_granted, grant_sel} !== {5'b01000, 3'd3}) begin
            failures++;
            $display("FAIL prio_high_wins got=%b/%0d exp=01000/3", master_granted, grant_sel);
        end
        $display("txn prio: granted=%b sel=%0d", master_granted, grant_sel);
        mst_req        = 5'b00001;
        mst_can_switch = 5'b01000;
        tick();
        checks++;
        if ({master_granted, grant_sel} !== {5'b00001, 3'd0}) begin
            failures++;
            $display("FAIL prio_handover got=%b/%0d exp=00001/0", master_granted, grant_sel);
        end
        $display("txn prio handover: granted=%b sel=%0d", master_granted, grant_sel);
        mst_req        = 5'b00000;
        mst_can_switch = 5'b11111;
        mst_priority   = '0;
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle got=%b exp=0", grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g;
        HRESETn = 1'b0;
        tick();
        HRESETn        = 1'b1;
        mst_priority   = '0;
        mst_req        = 5'b11111;
        mst_can_switch = 5'b11111;
        slv_HREADY     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_g = 5'b00001 << (k % 5);
            checks++;
            if ({master_granted, grant_sel} !== {exp_g, 3'(k % 5)}) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%b/%0d exp=%b/%0d", k, master_granted, grant_sel, exp_g, k % 5);
            end
            $display("txn rr %0d: granted=%b sel=%0d", k, master_granted, grant_sel);
        end
    endtask

    task automatic test_sole_owner();
        mst_req        = 5'b00001;
        mst_can_switch = 5'b11111;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({master_granted, grant_valid} !== {5'b00001, 1'b1}) begin
                failures++;
                $display("FAIL sole_owner_hold[%0d] got=%b/%b exp=00001/1", c, master_granted, grant_valid);
            end
            $display("txn sole %0d: granted=%b", c, master_granted);
        end
        // A request pulse from m3 while m0 is locked must be forgotten.
        mst_can_switch = 5'b00000;
        mst_req        = 5'b01001;
        tick();
        mst_req = 5'b00001;
        tick();
        mst_can_switch = 5'b11111;
        tick();
        checks++;
        if (master_granted !== 5'b00001) begin
            failures++;
            $display("FAIL pulse_not_remembered got=%b exp=00001", master_granted);
        end
        $display("txn pulse: granted=%b", master_granted);
        mst_req = 5'b00000;
        tick();
        checks++;
        if ({master_granted, grant_valid} !== {5'b00000, 1'b0}) begin
            failures++;
            $display("FAIL sole_release got=%b/%b exp=00000/0", master_granted, grant_valid);
        end
        $display("txn sole release: granted=%b", master_granted);
    endtask

    task automatic test_reset_mid_owned();
        mst_req = 5'b00010;
        tick();
        checks++;
        if (master_granted !== 5'b00010) begin
            failures++;
            $display("FAIL pre_reset_grant got=%b exp=00010", master_granted);
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00000, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got=%b/%0d/%b exp=00000/0/0", master_granted, grant_sel, grant_valid);
        end
        $display("txn async reset: granted=%b sel=%0d", master_granted, grant_sel);
        tick();
        HRESETn = 1'b1;
        mst_req = 5'b10100;
        tick();
        checks++;
        if ({master_granted, grant_sel, grant_valid} !== {5'b00100, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_tie got=%b/%0d/%b exp=00100/2/1", master_granted, grant_sel, grant_valid);
        end
        $display("txn post reset: granted=%b sel=%0d", master_granted, grant_sel);
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_hold_and_switch();
        test_priority();
        test_round_robin();
        test_sole_owner();
        test_reset_mid_owned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
